// File: rtl/dryer_panel_encoder_if.sv
// rtl/dryer_panel_encoder_if.sv - panel contacts in, controller codes and pulses out
interface dryer_panel_encoder_if;
   logic        BTN_ON;
   logic        BTN_OFF;
   logic        BTN_RST;
   logic [10:0] DIAL_POS;
   logic [3:0]  HEAT_POS;
   logic [0:3]  mainDial;
   logic [0:1]  heatDial;
   logic        ON;
   logic        OFF;
   logic        RST_REQ;
   logic        ON_REJECT;
   logic        DIAL_FAULT;

   modport master (
      output BTN_ON, BTN_OFF, BTN_RST, DIAL_POS, HEAT_POS,
      input  mainDial, heatDial, ON, OFF, RST_REQ, ON_REJECT, DIAL_FAULT
   );

   modport slave (
      input  BTN_ON, BTN_OFF, BTN_RST, DIAL_POS, HEAT_POS,
      output mainDial, heatDial, ON, OFF, RST_REQ, ON_REJECT, DIAL_FAULT
   );
endinterface

// File: rtl/dryer_panel_encoder.sv
// rtl/dryer_panel_encoder.sv - synchronise and debounce panel buttons and rotary dials
// Buttons become one-cycle pulses; dials become settled codes with a one-hot fault flag.
module dryer_panel_encoder #(
   parameter int DEB_CYCLES = 500
) (
   input logic                   CLK,
   input logic                   RESET,
   dryer_panel_encoder_if.slave  pnl
);
   localparam int              CW      = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CW-1:0]   CNT_MAX = CW'(DEB_CYCLES - 1);

   localparam logic [1:0] IDLE       = 2'd0;
   localparam logic [1:0] PRESS_WAIT = 2'd1;
   localparam logic [1:0] HELD       = 2'd2;
   localparam logic [1:0] REL_WAIT   = 2'd3;

   logic [17:0] sync_a;
   logic [17:0] sync_b;
   logic [10:0] dial_s;
   logic [3:0]  heat_s;
   logic [2:0]  btn_s;
   logic [2:0]  fire;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         sync_a <= '0;
         sync_b <= '0;
      end else begin
         sync_a <= {pnl.BTN_RST, pnl.BTN_OFF, pnl.BTN_ON, pnl.HEAT_POS, pnl.DIAL_POS};
         sync_b <= sync_a;
      end
   end

   assign dial_s = sync_b[10:0];
   assign heat_s = sync_b[14:11];
   assign btn_s  = sync_b[17:15];

   // Index 0 = ON, 1 = OFF, 2 = RESET button.
   for (genvar i = 0; i < 3; i++) begin : g_btn
      logic [1:0]    state;
      logic [CW-1:0] cnt;
      logic          armed;

      always_ff @(posedge CLK) begin
         if (RESET) begin
            state <= REL_WAIT;
            cnt   <= '0;
            armed <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (btn_s[i]) begin
                     state <= PRESS_WAIT;
                     cnt   <= '0;
                  end
               end
               PRESS_WAIT: begin
                  if (!btn_s[i])
                     state <= IDLE;
                  else if (cnt == CNT_MAX)
                     state <= HELD;
                  else
                     cnt <= cnt + CW'(1);
               end
               HELD: begin
                  if (!btn_s[i]) begin
                     state <= REL_WAIT;
                     cnt   <= '0;
                     armed <= 1'b1;
                  end
               end
               default: begin
                  // Unarmed only after reset: a button held through reset must be released first.
                  if (btn_s[i]) begin
                     if (armed)
                        state <= HELD;
                     else
                        cnt <= '0;
                  end else if (cnt == CNT_MAX) begin
                     state <= IDLE;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
            endcase
         end
      end

      assign fire[i] = (state == PRESS_WAIT) && btn_s[i] && (cnt == CNT_MAX);
   end

   function automatic logic [3:0] main_code(input logic [10:0] p);
      main_code = 4'h0;
      for (int i = 0; i < 11; i++) begin
         if (p[i]) begin
            case (i)
               0:       main_code = 4'h0;
               1:       main_code = 4'h1;
               2:       main_code = 4'h2;
               3:       main_code = 4'h4;
               4:       main_code = 4'h8;
               default: main_code = 4'(i + 5);
            endcase
         end
      end
   endfunction

   function automatic logic [1:0] heat_code(input logic [3:0] p);
      heat_code = 2'b00;
      for (int i = 0; i < 4; i++) begin
         if (p[i])
            heat_code = 2'(i);
      end
   endfunction

   logic [10:0]   main_cand;
   logic [CW-1:0] main_cnt;
   logic          main_settled;
   logic          main_fault;
   logic [3:0]    heat_cand;
   logic [CW-1:0] heat_cnt;
   logic          heat_settled;
   logic          heat_fault;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         main_cand    <= '0;
         main_cnt     <= '0;
         main_settled <= 1'b0;
         main_fault   <= 1'b0;
         pnl.mainDial <= 4'h0;
      end else if (dial_s != main_cand) begin
         main_cand    <= dial_s;
         main_cnt     <= '0;
         main_settled <= 1'b0;
      end else if (!main_settled) begin
         if (main_cnt == CNT_MAX) begin
            main_settled <= 1'b1;
            if ($onehot(main_cand)) begin
               pnl.mainDial <= main_code(main_cand);
               main_fault   <= 1'b0;
            end else begin
               main_fault   <= 1'b1;
            end
         end else begin
            main_cnt <= main_cnt + CW'(1);
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         heat_cand    <= '0;
         heat_cnt     <= '0;
         heat_settled <= 1'b0;
         heat_fault   <= 1'b0;
         pnl.heatDial <= 2'b00;
      end else if (heat_s != heat_cand) begin
         heat_cand    <= heat_s;
         heat_cnt     <= '0;
         heat_settled <= 1'b0;
      end else if (!heat_settled) begin
         if (heat_cnt == CNT_MAX) begin
            heat_settled <= 1'b1;
            if ($onehot(heat_cand)) begin
               pnl.heatDial <= heat_code(heat_cand);
               heat_fault   <= 1'b0;
            end else begin
               heat_fault   <= 1'b1;
            end
         end else begin
            heat_cnt <= heat_cnt + CW'(1);
         end
      end
   end

   assign pnl.DIAL_FAULT = main_fault | heat_fault;

   logic start_ok;
   assign start_ok = main_settled && heat_settled && !main_fault && !heat_fault;

   // OFF wins over a coincident ON; the suppressed ON is not reported as a reject.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         pnl.ON        <= 1'b0;
         pnl.OFF       <= 1'b0;
         pnl.RST_REQ   <= 1'b0;
         pnl.ON_REJECT <= 1'b0;
      end else begin
         pnl.ON        <= fire[0] && !fire[1] && start_ok;
         pnl.ON_REJECT <= fire[0] && !fire[1] && !start_ok;
         pnl.OFF       <= fire[1];
         pnl.RST_REQ   <= fire[2];
      end
   end
endmodule

// File: tb/tb_dryer_panel_encoder.sv
// tb/tb_dryer_panel_encoder.sv - scoreboard bench with run-length reference model
module tb_dryer_panel_encoder;
   localparam int DEB = 4;
   localparam int S_ON = 0, S_OFF = 1, S_RR = 2, S_REJ = 3, S_MAIN = 4, S_HEAT = 5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   bit   mon_en = 1'b0;

   always #5 clk = ~clk;

   dryer_panel_encoder_if pif ();
   dryer_panel_encoder #(.DEB_CYCLES(DEB)) dut (.CLK(clk), .RESET(rst), .pnl(pif));

   typedef struct {
      int          cyc;
      logic [10:0] outs;
   } ev_t;
   ev_t sb[$];

   logic [3:0] main_map [11] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int onehot_index(input logic [10:0] p);
      int n = 0;
      int idx = -1;
      for (int i = 0; i < 11; i++) begin
         if (p[i]) begin
            n++;
            idx = i;
         end
      end
      return (n == 1) ? idx : -1;
   endfunction

   // Model: a button's debounced level flips after an unbroken run of opposite samples.
   logic [2:0]  mb1, mb2;
   logic [10:0] md1, md2;
   logic [3:0]  mh1, mh2;
   int          lvl [3];
   int          run [3];
   bit          armed [3];
   logic [10:0] dprev;
   int          dcnt;
   bit          dset;
   logic [3:0]  hprev;
   int          hcnt;
   bit          hset;
   logic [3:0]  e_md = 4'h0;
   logic [1:0]  e_hd = 2'b00;
   bit          e_mf = 1'b0;
   bit          e_hf = 1'b0;
   logic [10:0] last_exp = '0;
   logic [10:0] last_dut = '0;

   always @(posedge clk) begin : model
      logic [2:0]  bx;
      logic [10:0] dx;
      logic [3:0]  hx;
      bit          fire [3];
      bit          ok;
      bit          e_on, e_off, e_rr, e_rej;
      int          idx;
      logic [10:0] now;
      cyc++;
      e_on = 0; e_off = 0; e_rr = 0; e_rej = 0;
      if (rst) begin
         mb1 = '0; mb2 = '0; md1 = '0; md2 = '0; mh1 = '0; mh2 = '0;
         for (int i = 0; i < 3; i++) begin
            lvl[i] = 1; run[i] = 0; armed[i] = 0;
         end
         dprev = '0; dcnt = 0; dset = 0;
         hprev = '0; hcnt = 0; hset = 0;
         e_md = 4'h0; e_hd = 2'b00; e_mf = 0; e_hf = 0;
      end else begin
         bx = mb2; dx = md2; hx = mh2;
         mb2 = mb1; md2 = md1; mh2 = mh1;
         mb1 = {pif.BTN_RST, pif.BTN_OFF, pif.BTN_ON};
         md1 = pif.DIAL_POS;
         mh1 = pif.HEAT_POS;
         ok = dset && hset && !e_mf && !e_hf;
         for (int i = 0; i < 3; i++) begin
            fire[i] = 0;
            if (lvl[i] == 0) begin
               if (bx[i]) begin
                  run[i]++;
                  if (run[i] == DEB + 1) begin
                     lvl[i] = 1; run[i] = 0; armed[i] = 1; fire[i] = 1;
                  end
               end else begin
                  run[i] = 0;
               end
            end else begin
               if (!bx[i]) begin
                  run[i]++;
                  if (run[i] == (armed[i] ? DEB + 1 : DEB)) begin
                     lvl[i] = 0; run[i] = 0;
                  end
               end else begin
                  run[i] = 0;
               end
            end
         end
         e_off = fire[1];
         e_rr  = fire[2];
         e_on  = fire[0] && !fire[1] && ok;
         e_rej = fire[0] && !fire[1] && !ok;
         if (dx != dprev) begin
            dprev = dx; dcnt = 0; dset = 0;
         end else if (!dset) begin
            dcnt++;
            if (dcnt == DEB) begin
               dset = 1;
               idx = onehot_index(dprev);
               if (idx >= 0) begin
                  e_md = main_map[idx]; e_mf = 0;
               end else begin
                  e_mf = 1;
               end
            end
         end
         if (hx != hprev) begin
            hprev = hx; hcnt = 0; hset = 0;
         end else if (!hset) begin
            hcnt++;
            if (hcnt == DEB) begin
               hset = 1;
               idx = onehot_index({7'b0, hprev});
               if (idx >= 0) begin
                  e_hd = 2'(idx); e_hf = 0;
               end else begin
                  e_hf = 1;
               end
            end
         end
      end
      now = {e_on, e_off, e_rr, e_rej, e_mf | e_hf, e_md, e_hd};
      if (e_on || e_off || e_rr || e_rej || now != last_exp)
         sb.push_back('{cyc, now});
      last_exp = now;
   end

   always @(negedge clk) begin : monitor
      logic [10:0] dnow;
      ev_t         e;
      if (mon_en) begin
         while (sb.size() > 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            check("missed_event", cyc, e.cyc);
         end
         dnow = {pif.ON, pif.OFF, pif.RST_REQ, pif.ON_REJECT, pif.DIAL_FAULT, pif.mainDial, pif.heatDial};
         if (dnow !== last_dut || (|dnow[10:7])) begin
            if (sb.size() == 0 || sb[0].cyc != cyc) begin
               check("unexpected_event", cyc, (sb.size() == 0) ? -1 : sb[0].cyc);
            end else begin
               e = sb.pop_front();
               check("event_outputs", dnow, e.outs);
            end
         end
         last_dut = dnow;
      end
   end

   function automatic logic [3:0] sig_val(input int which);
      case (which)
         S_ON:    return {3'b0, pif.ON};
         S_OFF:   return {3'b0, pif.OFF};
         S_RR:    return {3'b0, pif.RST_REQ};
         S_REJ:   return {3'b0, pif.ON_REJECT};
         S_MAIN:  return pif.mainDial;
         default: return {2'b0, pif.heatDial};
      endcase
   endfunction

   task automatic wait_sig(input int which, input logic [3:0] val, input int budget, output int t);
      t = -1;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         if (sig_val(which) == val) begin
            t = cyc;
            break;
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: actual cycle %0d, required finish before time limit", cyc);
      $fatal(1);
   end

   initial begin
      int t0, t, cnt, r, k;
      pif.BTN_ON = 0; pif.BTN_OFF = 0; pif.BTN_RST = 0;
      pif.DIAL_POS = 11'h002; pif.HEAT_POS = 4'b0001;
      idle(3);
      check("rst_mainDial", pif.mainDial, 0);
      check("rst_heatDial", pif.heatDial, 0);
      check("rst_on", pif.ON, 0);
      check("rst_off", pif.OFF, 0);
      check("rst_rst_req", pif.RST_REQ, 0);
      check("rst_on_reject", pif.ON_REJECT, 0);
      check("rst_dial_fault", pif.DIAL_FAULT, 0);
      mon_en = 1;
      @(negedge clk); rst = 0;
      idle(15);

      @(negedge clk); pif.BTN_ON = 1; t0 = cyc;
      wait_sig(S_ON, 1, 15, t);
      check("on_latency", t - t0, 7);
      @(negedge clk);
      check("on_width", pif.ON, 0);
      idle(12); pif.BTN_ON = 0; idle(10);

      @(negedge clk); pif.BTN_ON = 1;
      @(negedge clk); pif.BTN_ON = 0;
      @(negedge clk); pif.BTN_ON = 1;
      @(negedge clk); pif.BTN_ON = 0;
      @(negedge clk); pif.BTN_ON = 1; t0 = cyc;
      wait_sig(S_ON, 1, 15, t);
      check("bounce_latency", t - t0, 7);
      idle(10); pif.BTN_ON = 0; idle(10);

      @(negedge clk); pif.DIAL_POS = 11'h001;
      idle(10); pif.DIAL_POS = 11'h400; t0 = cyc;
      wait_sig(S_MAIN, 4'hF, 15, t);
      check("dial_latency", t - t0, 7);
      @(negedge clk); pif.DIAL_POS = 11'h003;
      idle(10);
      check("fault_code_hold", pif.mainDial, 4'hF);
      check("fault_level", pif.DIAL_FAULT, 1);

      @(negedge clk); pif.BTN_ON = 1; t0 = cyc;
      wait_sig(S_REJ, 1, 15, t);
      check("reject_latency", t - t0, 7);
      check("reject_on_low", pif.ON, 0);
      idle(8); pif.BTN_ON = 0; idle(10);

      @(negedge clk); pif.HEAT_POS = 4'b1000; t0 = cyc;
      wait_sig(S_HEAT, 4'h3, 15, t);
      check("heat_latency", t - t0, 7);
      @(negedge clk); pif.DIAL_POS = 11'h002;
      idle(10);
      check("fault_cleared", pif.DIAL_FAULT, 0);

      @(negedge clk); pif.BTN_ON = 1; pif.BTN_OFF = 1; t0 = cyc;
      wait_sig(S_OFF, 1, 15, t);
      check("off_latency", t - t0, 7);
      check("onoff_on_low", pif.ON, 0);
      check("onoff_reject_low", pif.ON_REJECT, 0);
      idle(8); pif.BTN_ON = 0; pif.BTN_OFF = 0; idle(10);

      @(negedge clk); pif.BTN_RST = 1;
      idle(10); rst = 1; idle(2); rst = 0;
      cnt = 0;
      repeat (14) begin
         @(negedge clk);
         if (pif.RST_REQ) cnt++;
      end
      check("held_through_reset_no_req", cnt, 0);
      pif.BTN_RST = 0; idle(6);
      pif.BTN_RST = 1; t0 = cyc;
      wait_sig(S_RR, 1, 15, t);
      check("rst_req_latency", t - t0, 7);
      idle(6); pif.BTN_RST = 0; idle(10);

      @(negedge clk); pif.BTN_ON = 1;
      idle(3); rst = 1;
      @(negedge clk); rst = 0; pif.BTN_ON = 0;
      cnt = 0;
      repeat (15) begin
         @(negedge clk);
         if (pif.ON || pif.ON_REJECT) cnt++;
      end
      check("aborted_press_no_pulse", cnt, 0);

      for (int it = 0; it < 250; it++) begin
         r = $urandom_range(0, 99);
         @(negedge clk);
         if (r < 45) begin
            pif.BTN_ON = ~pif.BTN_ON;
         end else if (r < 60) begin
            pif.BTN_OFF = ~pif.BTN_OFF;
         end else if (r < 70) begin
            pif.BTN_RST = ~pif.BTN_RST;
         end else if (r < 85) begin
            k = $urandom_range(0, 10);
            pif.DIAL_POS = (r < 82) ? 11'(1 << k) : 11'($urandom);
         end else if (r < 97) begin
            k = $urandom_range(0, 3);
            pif.HEAT_POS = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'(1 << k);
         end else begin
            rst = 1;
            @(negedge clk); rst = 0;
         end
         idle($urandom_range(0, 7));
      end

      @(negedge clk);
      pif.BTN_ON = 0; pif.BTN_OFF = 0; pif.BTN_RST = 0;
      pif.DIAL_POS = 11'h002; pif.HEAT_POS = 4'b0001;
      idle(40);
      check("queue_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
